// File: rtl/axis_pkg.sv
//------------------------------------------------------------------------------
// Module  : axis_pkg
// Brief   : Shared AXI-Stream helpers: counter width and lane keep-mask builder.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package axis_pkg;

    localparam int c_max_lanes = 64;

    // Width of a lane counter able to hold 0..ratio-1; never narrower than one bit.
    function automatic int axis_cnt_w(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

    // Contiguous low-lane mask with lanes 0..idx set.
    function automatic logic [c_max_lanes-1:0] axis_keep_mask(input int idx);
        logic [c_max_lanes-1:0] m;
        m = '0;
        for (int i = 0; i < c_max_lanes; i++) begin
            m[i] = (i <= idx);
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_upsizer.sv
//------------------------------------------------------------------------------
// Module  : axis_upsizer
// Brief   : AXI-Stream width up-converter; packs P_RATIO narrow beats per wide
//           word and flushes a partial word early on s_axis_tlast.
//           Optional m_axis_tkeep output when AXIS_UPSIZER_TKEEP_EN is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module axis_upsizer
    import axis_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_RATIO      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [P_DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [P_DATA_WIDTH*P_RATIO-1:0] m_axis_tdata,
`ifdef AXIS_UPSIZER_TKEEP_EN
    output logic [P_RATIO-1:0]              m_axis_tkeep,
`endif
    output logic                            m_axis_tlast
);

    localparam int c_cnt_w = axis_cnt_w(P_RATIO);
    localparam int c_out_w = P_DATA_WIDTH * P_RATIO;

    logic [c_cnt_w-1:0] r_lane_cnt;
    logic [c_out_w-1:0] r_acc;
    logic [c_out_w-1:0] r_out_data;
    logic               r_out_valid;
    logic               r_out_last;

    logic               w_accept;
    logic               w_last_lane;
    logic               w_complete;
    logic [c_out_w-1:0] w_merged;

    // Input readiness looks only at the output register, so an upstream
    // register slice never sees a combinational path from its own tvalid.
    assign s_axis_tready = !r_out_valid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_last_lane   = (r_lane_cnt == c_cnt_w'(P_RATIO - 1));
    assign w_complete    = w_accept && (w_last_lane || s_axis_tlast);

    // Accumulator with the incoming beat dropped into the current lane.
    for (genvar gi = 0; gi < P_RATIO; gi++) begin : g_lane
        assign w_merged[gi*P_DATA_WIDTH +: P_DATA_WIDTH] =
            (r_lane_cnt == c_cnt_w'(gi)) ? s_axis_tdata
                                         : r_acc[gi*P_DATA_WIDTH +: P_DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane_cnt <= '0;
            r_acc      <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_lane_cnt <= '0;
                r_acc      <= '0;
            end else begin
                r_lane_cnt <= r_lane_cnt + c_cnt_w'(1);
                r_acc      <= w_merged;
            end
        end
    end

    // A completing beat can only arrive while the output slot is free or
    // draining, so loading here never disturbs a stalled word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_merged;
            r_out_last  <= s_axis_tlast;
        end else if (r_out_valid && m_axis_tready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef AXIS_UPSIZER_TKEEP_EN
    logic [P_RATIO-1:0] r_out_keep;
    logic [P_RATIO-1:0] w_keep;

    assign w_keep = P_RATIO'(axis_keep_mask(int'(r_lane_cnt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_keep <= '0;
        end else if (w_complete) begin
            r_out_keep <= w_keep;
        end
    end

    assign m_axis_tkeep = r_out_keep;
`endif

    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;

endmodule

`default_nettype wire
